clock_digit_sequencer: RTL and testbench

Timekeeping and refresh controller for the six 4-bit seven-segment digit output ports of the clock system. Keeps the HH:MM:SS time in BCD, advances it once per second from a clock-cycle prescaler, and after every change writes all six digits to the digit ports over a shared Avalon-MM write bus with one-hot chip selects. It is the only master of the digit ports; software changes time only through the set interface.

---
 rtl/clock_digit_sequencer.sv | 175 +++++++++++++++++
 tb/tb_clock_digit_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_digit_sequencer.sv
// clock_digit_sequencer: keeps HH:MM:SS in BCD, advances it once per second,
// and refreshes the six seven-segment digit ports after every time change.
//
// state | meaning
// IDLE  | no refresh in progress, waiting for a time change
// WR0   | writing Su (digit 0) from the snapshot
// WR1   | writing St (digit 1)
// WR2   | writing Mu (digit 2)
// WR3   | writing Mt (digit 3)
// WR4   | writing Hu (digit 4)
// WR5   | writing Ht (digit 5); restart at WR0 if another change is pending
module clock_digit_sequencer #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        set_valid,
  input  logic [23:0] set_time,
  output logic        set_err,
  output logic [23:0] time_bcd,
  output logic        busy,
  output logic [5:0]  pio_chipselect,
  output logic        pio_write_n,
  output logic [1:0]  pio_address,
  output logic [31:0] pio_writedata
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC_LOAD = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    WR1  = 3'd2,
    WR2  = 3'd3,
    WR3  = 3'd4,
    WR4  = 3'd5,
    WR5  = 3'd6
  } state_t;

  state_t      state, state_d;
  logic [CW-1:0] presc;
  logic [23:0] snap, snap_d;
  logic        pending, consume;
  logic        set_ok, tick, time_chg;
  logic [5:0]  cs_d;
  logic [3:0]  digit_d;

  function automatic logic bcd_legal(input logic [23:0] t);
    logic ok;
    ok = (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) &&
         (t[11:8] <= 4'd9) && (t[15:12] <= 4'd5) &&
         (t[19:16] <= 4'd9) && (t[23:20] <= 4'd2) &&
         !((t[23:20] == 4'd2) && (t[19:16] > 4'd3));
    return ok;
  endfunction

  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [23:0] r;
    r = t;
    if (t[3:0] != 4'd9) r[3:0] = t[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd5) r[7:4] = t[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (t[11:8] != 4'd9) r[11:8] = t[11:8] + 4'd1;
        else begin
          r[11:8] = 4'd0;
          if (t[15:12] != 4'd5) r[15:12] = t[15:12] + 4'd1;
          else begin
            r[15:12] = 4'd0;
            if (t[23:16] == 8'h23) r[23:16] = 8'h00;
            else if (t[19:16] == 4'd9) begin
              r[19:16] = 4'd0;
              r[23:20] = t[23:20] + 4'd1;
            end else r[19:16] = t[19:16] + 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  // prescaler counts down the cycles left in the current second; 0 with enable is the tick
  assign set_ok   = set_valid && bcd_legal(set_time);
  assign tick     = enable && (presc == '0);
  assign time_chg = set_ok || tick;
  assign pio_address = 2'b00;

  // time-of-day register, prescaler and set rejection pulse; a set overrides a coincident tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= TC_LOAD;
      time_bcd <= 24'h000000;
      set_err  <= 1'b0;
    end else begin
      set_err <= set_valid && !set_ok;
      if (set_ok) begin
        time_bcd <= set_time;
        presc    <= TC_LOAD;
      end else if (tick) begin
        time_bcd <= bcd_inc(time_bcd);
        presc    <= TC_LOAD;
      end else if (enable) begin
        presc <= presc - 1'b1;
      end
    end
  end

  // next-state: walk the six digits, snapshotting time whenever a sequence starts
  always_comb begin
    state_d = state;
    snap_d  = snap;
    consume = 1'b0;
    case (state)
      IDLE: if (pending) begin
        consume = 1'b1;
        snap_d  = time_bcd;
        state_d = WR0;
      end
      WR0: state_d = WR1;
      WR1: state_d = WR2;
      WR2: state_d = WR3;
      WR3: state_d = WR4;
      WR4: state_d = WR5;
      WR5: if (pending) begin
        consume = 1'b1;
        snap_d  = time_bcd;
        state_d = WR0;
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // bus values for the upcoming state, so they can be registered alongside it
  always_comb begin
    cs_d    = 6'b000000;
    digit_d = 4'd0;
    case (state_d)
      WR0: begin cs_d = 6'b000001; digit_d = snap_d[3:0];   end
      WR1: begin cs_d = 6'b000010; digit_d = snap_d[7:4];   end
      WR2: begin cs_d = 6'b000100; digit_d = snap_d[11:8];  end
      WR3: begin cs_d = 6'b001000; digit_d = snap_d[15:12]; end
      WR4: begin cs_d = 6'b010000; digit_d = snap_d[19:16]; end
      WR5: begin cs_d = 6'b100000; digit_d = snap_d[23:20]; end
      default: begin cs_d = 6'b000000; digit_d = 4'd0; end
    endcase
  end

  // state, snapshot, pending flag and registered bus outputs; pending starts set to force a zero refresh
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      snap           <= 24'h000000;
      pending        <= 1'b1;
      busy           <= 1'b0;
      pio_chipselect <= 6'b000000;
      pio_write_n    <= 1'b1;
      pio_writedata  <= 32'h0;
    end else begin
      state          <= state_d;
      snap           <= snap_d;
      pending        <= time_chg || (pending && !consume);
      busy           <= (state_d != IDLE);
      pio_chipselect <= cs_d;
      pio_write_n    <= (cs_d == 6'b000000);
      pio_writedata  <= {28'h0, digit_d};
    end
  end

endmodule

// File: tb/tb_clock_digit_sequencer.sv
// tb_clock_digit_sequencer: directed and random stimulus against a seconds-based reference model.
module tb_clock_digit_sequencer;

  localparam int TD = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        set_valid = 1'b0;
  logic [23:0] set_time = 24'h0;
  logic        set_err;
  logic [23:0] time_bcd;
  logic        busy;
  logic [5:0]  pio_chipselect;
  logic        pio_write_n;
  logic [1:0]  pio_address;
  logic [31:0] pio_writedata;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: time as seconds since midnight, refresh position -1 = idle
  int m_secs, m_presc, m_pos, m_snap;
  bit m_pend, m_err;

  logic [3:0] wq[$];
  int n_busy;
  int e2[12] = '{8, 5, 9, 5, 3, 2, 9, 5, 9, 5, 3, 2};
  int e5[9];
  logic [23:0] old_bcd;

  clock_digit_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .set_valid(set_valid), .set_time(set_time), .set_err(set_err),
    .time_bcd(time_bcd), .busy(busy), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_address(pio_address),
    .pio_writedata(pio_writedata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] secs2bcd(input int s);
    int h, m, c;
    h = s / 3600;
    m = (s / 60) % 60;
    c = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic int digit_of(input int s, input int i);
    int d[6];
    d[0] = (s % 60) % 10;
    d[1] = (s % 60) / 10;
    d[2] = ((s / 60) % 60) % 10;
    d[3] = ((s / 60) % 60) / 10;
    d[4] = (s / 3600) % 10;
    d[5] = (s / 3600) / 10;
    return d[i];
  endfunction

  function automatic bit legal_m(input logic [23:0] t);
    int su, st, mu, mt, hu, ht;
    su = int'(t[3:0]);   st = int'(t[7:4]);   mu = int'(t[11:8]);
    mt = int'(t[15:12]); hu = int'(t[19:16]); ht = int'(t[23:20]);
    return (su <= 9) && (st <= 5) && (mu <= 9) && (mt <= 5) && (hu <= 9) && (ht * 10 + hu <= 23);
  endfunction

  function automatic int bcd2secs(input logic [23:0] t);
    return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600 +
           (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
           int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_secs = 0; m_presc = 0; m_pos = -1; m_snap = 0; m_pend = 1'b1; m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit ok, tk;
    ok = set_valid && legal_m(set_time);
    tk = enable && (m_presc == TD - 1);
    m_err = set_valid && !legal_m(set_time);
    if ((m_pos == -1 || m_pos == 5) && m_pend) begin
      m_snap = m_secs; m_pend = 1'b0; m_pos = 0;
    end else if (m_pos == 5) m_pos = -1;
    else if (m_pos >= 0) m_pos++;
    if (ok || tk) m_pend = 1'b1;
    if (ok) begin
      m_secs = bcd2secs(set_time); m_presc = 0;
    end else if (tk) begin
      m_secs = (m_secs + 1) % 86400; m_presc = 0;
    end else if (enable) m_presc++;
  endtask

  task automatic check_outputs();
    chk("time_bcd",   32'(time_bcd),       32'(secs2bcd(m_secs)));
    chk("set_err",    32'(set_err),        32'(m_err));
    chk("busy",       32'(busy),           32'(m_pos >= 0));
    chk("chipselect", 32'(pio_chipselect), (m_pos >= 0) ? 32'(1 << m_pos) : 32'h0);
    chk("write_n",    32'(pio_write_n),    32'(m_pos < 0));
    chk("writedata",  pio_writedata,       (m_pos >= 0) ? 32'(digit_of(m_snap, m_pos)) : 32'h0);
    chk("address",    32'(pio_address),    32'h0);
    if (pio_write_n == 1'b0) chk("onehot_cs", 32'($onehot(pio_chipselect)), 32'h1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (pio_write_n == 1'b0) wq.push_back(pio_writedata[3:0]);
    if (busy) n_busy++;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && busy; k++) step();
    chk("wait_idle", 32'(busy), 32'h0);
  endtask

  task automatic wait_cs(input logic [5:0] cs);
    for (int k = 0; k < 40 && pio_chipselect != cs; k++) step();
    chk("wait_cs", 32'(pio_chipselect), 32'(cs));
  endtask

  initial begin
    int k;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // zero refresh after reset release
    wq.delete(); n_busy = 0;
    repeat (12) step();
    chk("refresh_writes", 32'(wq.size()), 32'd6);
    chk("refresh_busy", 32'(n_busy), 32'd6);
    for (int i = 0; i < 6 && i < wq.size(); i++) chk("refresh_zero", 32'(wq[i]), 32'h0);

    // rollover through midnight
    wait_idle();
    wq.delete();
    enable = 1'b1; set_valid = 1'b1; set_time = 24'h235958;
    step();
    set_valid = 1'b0;
    repeat (8) step();
    chk("tick1_time", 32'(time_bcd), 32'h235959);
    repeat (8) step();
    chk("midnight_time", 32'(time_bcd), 32'h000000);
    chk("rollover_writes", 32'(wq.size()), 32'd12);
    for (int i = 0; i < 12 && i < wq.size(); i++) chk($sformatf("rollover_d%0d", i), 32'(wq[i]), 32'(e2[i]));
    wq.delete();
    repeat (7) step();
    enable = 1'b0;
    chk("midnight_writes", 32'(wq.size()), 32'd6);
    for (int i = 0; i < 6 && i < wq.size(); i++) chk("midnight_zero", 32'(wq[i]), 32'h0);

    // rejected sets
    wait_idle();
    wq.delete();
    old_bcd = secs2bcd(m_secs);
    set_valid = 1'b1; set_time = 24'h245900;
    step();
    chk("err_hours", 32'(set_err), 32'h1);
    set_valid = 1'b0;
    step();
    chk("err_clear", 32'(set_err), 32'h0);
    set_valid = 1'b1; set_time = 24'h126000;
    step();
    chk("err_minutes", 32'(set_err), 32'h1);
    set_valid = 1'b0;
    repeat (4) step();
    chk("err_time_kept", 32'(time_bcd), 32'(old_bcd));
    chk("err_no_writes", 32'(wq.size()), 32'h0);

    // set coincident with tick
    enable = 1'b1;
    for (k = 0; k < 2 * TD && m_presc != TD - 1; k++) step();
    set_valid = 1'b1; set_time = 24'h101010;
    step();
    set_valid = 1'b0;
    chk("set_wins", 32'(time_bcd), 32'h101010);
    k = 0;
    while (time_bcd == 24'h101010 && k < 20) begin step(); k++; end
    chk("tick_after_set", 32'(k), 32'd8);

    // set during WR2
    wait_cs(6'b000100);
    enable = 1'b0;
    old_bcd = secs2bcd(m_secs);
    e5 = '{int'(old_bcd[15:12]), int'(old_bcd[19:16]), int'(old_bcd[23:20]), 4, 3, 2, 1, 7, 0};
    wq.delete();
    set_valid = 1'b1; set_time = 24'h071234;
    step();
    set_valid = 1'b0;
    repeat (8) step();
    chk("midseq_writes", 32'(wq.size()), 32'd9);
    for (int i = 0; i < 9 && i < wq.size(); i++) chk($sformatf("midseq_d%0d", i), 32'(wq[i]), 32'(e5[i]));

    // reset during WR3
    wait_idle();
    set_valid = 1'b1; set_time = 24'h000001;
    step();
    set_valid = 1'b0;
    wait_cs(6'b001000);
    #2 reset = 1'b1;
    #1;
    chk("rst_cs", 32'(pio_chipselect), 32'h0);
    chk("rst_write_n", 32'(pio_write_n), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_time", 32'(time_bcd), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    wq.delete();
    repeat (10) step();
    chk("rst_refresh_writes", 32'(wq.size()), 32'd6);
    for (int i = 0; i < 6 && i < wq.size(); i++) chk("rst_refresh_zero", 32'(wq[i]), 32'h0);

    // random traffic
    for (int r = 0; r < 1500; r++) begin
      enable = ($urandom_range(0, 3) != 0);
      set_valid = 1'b0;
      if ($urandom_range(0, 29) == 0) begin
        set_valid = 1'b1;
        case ($urandom_range(0, 2))
          0: set_time = secs2bcd(int'($urandom_range(0, 86399)));
          1: set_time = secs2bcd(86400 - int'($urandom_range(1, 5)));
          default: begin set_time = 24'($urandom); enable = 1'b0; end
        endcase
      end
      step();
    end
    set_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
